kbd_event_ctrl: RTL
===================

# kbd_event_ctrl

Receive controller and scan-code sequencer for the PS/2 keyboard path. It samples the raw `kbdclk`/`kbddata` lines in the system clock domain and frames each 11-bit PS/2 packet with start, parity and stop checks and an inter-bit watchdog. It folds the `E0`/`F0` prefix bytes into key events and queues them in a small FIFO with a valid/ready pop port for the downstream consumer.

## Interface
- `TIMEOUT_CYC`, default 5000: system clocks allowed between kbdclk falling edges inside a frame before the frame is aborted.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of 2, ≥2.

- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `kbdclk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `kbddata`  in  1  raw PS/2 data, asynchronous to `clk`.
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_code`  out  8  scan code of the head event.
- `ev_break`  out  1  head event is a key release (`F0`-prefixed).
- `ev_ext`  out  1  head event is extended (`E0`-prefixed).
- `frame_err`  out  1  one-cycle pulse on parity, stop or timeout error.
- `overflow`  out  1  one-cycle pulse when an event is dropped because the FIFO is full.
- `busy`  out  1  frame FSM is not in IDLE.

## Operation
- **Input synchronizer.** `kbdclk` and `kbddata` each pass through 2 flops; both reset to 1.
- **Edge detect.** `fall` = previous synced `kbdclk` is 1 and current synced `kbdclk` is 0. The edge-detect flop resets to 1.
- **Frame FSM.** States: IDLE, DATA, PARITY, STOP. Every action samples synced `kbddata` on `fall`.
  - IDLE: data 0 → DATA, bit count = 0. Data 1 → stay in IDLE (stray edge ignored).
  - DATA: shift data into bit `[cnt]`, LSB first. After 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: good frame requires odd parity (XOR of 8 data bits and the parity bit = 1) and stop bit = 1.
    - Good frame → `byte_stb` with the byte.
    - Otherwise → `frame_err`.
    - Either outcome → IDLE.
- **Watchdog.** Counter clears on every `fall` and in IDLE. Otherwise it increments. At `TIMEOUT_CYC-1` without a `fall`: → IDLE, pulse `frame_err`, discard the partial byte.
- **Decoder.** Holds two flags, `pend_ext` and `pend_brk`.
  - Byte `E0` → set `pend_ext`; no event.
  - Byte `F0` → set `pend_brk`; no event.
  - Any other byte → push `{code, pend_brk, pend_ext}` and clear both flags.
  - `frame_err` clears both flags.
- **FIFO.** `ev_*` outputs come from the head entry; `ev_valid` = not empty. Pop when `ev_valid && ev_ready`.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Otherwise the event is dropped, `overflow` pulses, and the decoder flags still clear.
  - Pointers wrap modulo `FIFO_DEPTH`. An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
  - Events leave in arrival order.

## Timing
- **Reset values.** `ev_valid`, `ev_code`, `ev_break`, `ev_ext`, `frame_err`, `overflow`, `busy` are all 0. FIFO empty, FSM in IDLE, flags clear, watchdog 0.
- **Reset mid-frame or mid-prefix.** The partial frame and pending flags are discarded, with no `frame_err`. Queued events are lost.
- **Reference cycle.** Let E = the `clk` edge at which `fall` is registered for a stop or parity edge.
  - `byte_stb`/`frame_err` are high during cycle E+1, for exactly one cycle.
  - The FIFO write occurs at the end of E+1.
  - `ev_valid` rises in cycle E+2, provided the FIFO was empty.
  - `overflow` is high during cycle E+1.
- **Raw-to-event latency.** From the raw stop-bit falling edge, a pushed event appears within 5 `clk` cycles.
- **Watchdog timing.** Timeout `frame_err` pulses `TIMEOUT_CYC` cycles after the last `fall`, ±1.
- **Simultaneous push and pop.**
  - When the FIFO is full: occupancy stays full and the new entry goes to the tail.
  - When the FIFO holds 1 entry: occupancy stays 1 and `ev_valid` stays high.
- **Output stability.** `ev_code`/`ev_break`/`ev_ext` are stable while `ev_valid && !ev_ready`.
- **Busy.** `busy` is high from the cycle after the start-bit `fall` until the cycle FSM returns to IDLE.

## Test plan
- Make code: frame 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1), `ev_ready`=1 → one event: `ev_code`=1C, `ev_break`=0, `ev_ext`=0; `frame_err` never pulses.
- Break and extended break:
  - Frames F0,1C → single event 1C with `ev_break`=1, `ev_ext`=0.
  - Frames E0,F0,74 → single event 74 with `ev_break`=1, `ev_ext`=1.
- Parity error: F0, then 0x1C with parity bit 1, then a good 0x1C.
  - Bad frame → one `frame_err` pulse and no event.
  - Good 0x1C → event with `ev_break`=0 (flag cleared).
- Timeout: start + 5 data bits, then idle `TIMEOUT_CYC`+10 cycles.
  - One `frame_err` pulse; `busy` returns to 0.
  - A following good 0x2A yields event 2A.
- Overflow: `ev_ready`=0, send makes 0x15,0x1D,0x24,0x2D,0x2C.
  - `overflow` pulses once, on the 5th.
  - Raising `ev_ready` drains 15,1D,24,2D in order, then `ev_valid`=0.
- Reset: assert `rst_n`=0 for 1 cycle after 4 data bits of a frame.
  - All outputs 0 the next cycle and no `frame_err`.
  - The next full frame 0x1C decodes correctly.

Source files
------------

// File: rtl/kbd_event_ctrl.sv
// PS/2 keyboard receiver: synchronises raw kbdclk/kbddata, frames 11-bit packets,
// folds E0/F0 prefixes into key events and queues them behind a valid/ready port.
module kbd_event_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbdclk,
    input  logic       kbddata,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input synchroniser and edge detect
    logic kclk_meta_q, kclk_sync_q, kclk_prev_q;
    logic kdat_meta_q, kdat_sync_q;
    logic fall;

    // Frame FSM
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              byte_stb_q, byte_stb_d;
    logic              frame_err_q, frame_err_d;

    // Decoder and FIFO
    logic              pend_ext_q, pend_ext_d;
    logic              pend_brk_q, pend_brk_d;
    logic [9:0]        mem_q [FIFO_DEPTH];
    logic [9:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_req, push, pop, full;
    logic              is_e0, is_f0;

    assign fall = kclk_prev_q & ~kclk_sync_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        byte_stb_d  = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == S_IDLE || fall) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + WD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fall && !kdat_sync_q) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d[cnt_q] = kdat_sync_q;
                    cnt_d          = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = kdat_sync_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    if ((^{shift_q, par_q}) && kdat_sync_q) begin
                        byte_stb_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog overrides any in-frame progress and discards the partial byte
        if (state_q != S_IDLE && !fall && wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            shift_d     = '0;
            wdog_d      = '0;
        end
    end

    assign is_e0    = (shift_q == 8'hE0);
    assign is_f0    = (shift_q == 8'hF0);
    assign push_req = byte_stb_q && !is_e0 && !is_f0;
    assign ev_valid = (count_q != '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ready;
    assign push     = push_req && (!full || pop);

    always_comb begin
        pend_ext_d = pend_ext_q;
        pend_brk_d = pend_brk_q;
        if (frame_err_q) begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
        end else if (byte_stb_q) begin
            if (is_e0) begin
                pend_ext_d = 1'b1;
            end else if (is_f0) begin
                pend_brk_d = 1'b1;
            end else begin
                // Flags clear even when the event is dropped on overflow
                pend_ext_d = 1'b0;
                pend_brk_d = 1'b0;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {shift_q, pend_brk_q, pend_ext_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kclk_meta_q <= 1'b1;
            kclk_sync_q <= 1'b1;
            kclk_prev_q <= 1'b1;
            kdat_meta_q <= 1'b1;
            kdat_sync_q <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            wdog_q      <= '0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            pend_ext_q  <= 1'b0;
            pend_brk_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            kclk_meta_q <= kbdclk;
            kclk_sync_q <= kclk_meta_q;
            kclk_prev_q <= kclk_sync_q;
            kdat_meta_q <= kbddata;
            kdat_sync_q <= kdat_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            wdog_q      <= wdog_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
            pend_ext_q  <= pend_ext_d;
            pend_brk_q  <= pend_brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign ev_code   = mem_q[rd_ptr_q][9:2];
    assign ev_break  = mem_q[rd_ptr_q][1];
    assign ev_ext    = mem_q[rd_ptr_q][0];
    assign frame_err = frame_err_q;
    assign overflow  = push_req && !push;
    assign busy      = (state_q != S_IDLE);

endmodule
